// File: rtl/button_event_pkg.sv
// Shared types for the button event block: FSM states and event codes.
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } event_code_t;

endpackage

// File: rtl/event_latch.sv
// Sticky event register with valid/ack handshake; a new event always wins over ack.
module event_latch
  import button_event_pkg::*;
(
  input  logic        clk,
  input  logic        nReset,
  input  logic        evt_in,
  input  logic [1:0]  evt_code,
  input  logic        event_ack,
  output logic        event_valid,
  output logic [1:0]  event_code,
  output logic        overflow
);

  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    if (evt_in) begin
      valid_d = 1'b1;
      code_d  = evt_code;
      // overflow is only ever set while valid is set, so valid_q alone decides it
      ovf_d   = event_ack ? 1'b0 : valid_q;
    end else if (event_ack && valid_q) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      valid_q <= 1'b0;
      code_q  <= EV_PRESS;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  assign event_valid = valid_q;
  assign event_code  = code_q;
  assign overflow    = ovf_q;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long/repeat pulses plus a sticky event register.
// The release output is named release_pulse because "release" is a reserved word.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 200,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       in,
  input  logic       event_ack,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             rpt_q, rpt_d;
  logic             held_q, held_d;
  logic             evt_fire;
  event_code_t      evt_code;

  assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          count_d = CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!in) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
          count_d = '0;
        end else if (count_q == LONG_LAST) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_inc;
        end
      end
      ST_LONG: begin
        if (!in) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
          count_d = '0;
        end else if (count_q == REPEAT_LAST) begin
          rpt_d   = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    held_d = (state_d != ST_IDLE);
  end

  always_comb begin
    evt_fire = press_d | rel_d | long_d | rpt_d;
    evt_code = EV_PRESS;
    if (rel_d)       evt_code = EV_RELEASE;
    else if (long_d) evt_code = EV_LONG;
    else if (rpt_d)  evt_code = EV_REPEAT;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
    end
  end

  // Fed from the next-state pulses so the register updates on the same edge as the pulse
  event_latch u_event_latch (
    .clk         (clk),
    .nReset      (nReset),
    .evt_in      (evt_fire),
    .evt_code    (evt_code),
    .event_ack   (event_ack),
    .event_valid (event_valid),
    .event_code  (event_code),
    .overflow    (overflow)
  );

  assign press         = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;
  assign repeat_pulse  = rpt_q;
  assign held          = held_q;

endmodule
